// File: rtl/base_rrarb.sv
// Round-robin arbiter with grant lock: merges `ways` valid/ready channels onto one output.
// Optional BASE_RRARB_LAST_EN adds i_last and holds the grant for a whole packet.
module base_rrarb #(
    parameter int ways = 4,
    localparam int encw = ($clog2(ways) > 0) ? $clog2(ways) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ways-1:0] i_v,
`ifdef BASE_RRARB_LAST_EN
    input  logic [ways-1:0] i_last,
`endif
    output logic [ways-1:0] i_r,
    output logic            o_v,
    input  logic            o_r,
    output logic [ways-1:0] o_sel,
    output logic [encw-1:0] o_sel_enc
);

    // Handshake: a beat moves when valid & ready are both high on a rising edge;
    // a source holding valid must keep it (and its data) until it sees ready.

    logic [encw-1:0] ptr;
    logic            lock;
    logic [ways-1:0] lsel;

    logic [ways-1:0] fresh;
    logic            found;
    logic [encw:0]   sum;
    logic [encw-1:0] idx;
    logic [ways-1:0] sel;
    logic [encw-1:0] sel_enc;
    logic [encw-1:0] ptr_next;
    logic            last_beat;

    // Circular search starting at ptr; sum is one bit wider so ways == 2**encw fits.
    always_comb begin
        fresh = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < ways; i++) begin
            sum = {1'b0, ptr} + (encw+1)'(i);
            if (sum >= (encw+1)'(ways)) begin
                sum = sum - (encw+1)'(ways);
            end
            idx = sum[encw-1:0];
            if (!found && i_v[idx]) begin
                found      = 1'b1;
                fresh[idx] = 1'b1;
            end
        end
    end

    assign sel = lock ? (lsel & i_v) : fresh;

    always_comb begin
        sel_enc = '0;
        for (int j = 0; j < ways; j++) begin
            if (sel[j]) begin
                sel_enc = sel_enc | encw'(j);
            end
        end
    end

    assign o_sel     = reset ? '0 : sel;
    assign o_sel_enc = reset ? '0 : sel_enc;
    assign o_v       = |o_sel;
    assign i_r       = o_sel & {ways{o_r}};

`ifdef BASE_RRARB_LAST_EN
    assign last_beat = |(i_last & sel);
`else
    assign last_beat = 1'b1;
`endif

    assign ptr_next = (sel_enc == encw'(ways - 1)) ? '0 : sel_enc + encw'(1);

    // A stall or a mid-packet beat keeps the grant; only a last beat rotates priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= '0;
            lock <= 1'b0;
            lsel <= '0;
        end else if (o_v) begin
            if (!o_r || !last_beat) begin
                lock <= 1'b1;
                lsel <= sel;
            end else begin
                lock <= 1'b0;
                lsel <= '0;
                ptr  <= ptr_next;
            end
        end
    end

    locked_way_holds_valid: assert property (@(posedge clk) disable iff (reset) lock |-> |(lsel & i_v));

endmodule

// File: tb/tb_base_rrarb.sv
// Bench for base_rrarb: directed scenarios on a 4-way instance, then random traffic
// on 4-way and 3-way instances against an index-based round-robin reference model.
module tb_base_rrarb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] iv4, ir4, sel4;
    logic       or4, ov4;
    logic [1:0] enc4;
    logic [2:0] iv3, ir3, sel3;
    logic       or3, ov3;
    logic [1:0] enc3;
`ifdef BASE_RRARB_LAST_EN
    logic [3:0] last4;
    logic [2:0] last3;
    logic [3:0] rl[2];
`endif

    base_rrarb #(.ways(4)) u_dut4 (
        .clk(clk), .reset(reset), .i_v(iv4),
`ifdef BASE_RRARB_LAST_EN
        .i_last(last4),
`endif
        .i_r(ir4), .o_v(ov4), .o_r(or4), .o_sel(sel4), .o_sel_enc(enc4)
    );

    base_rrarb #(.ways(3)) u_dut3 (
        .clk(clk), .reset(reset), .i_v(iv3),
`ifdef BASE_RRARB_LAST_EN
        .i_last(last3),
`endif
        .i_r(ir3), .o_v(ov3), .o_r(or3), .o_sel(sel3), .o_sel_enc(enc3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: pointer, lock flag and locked way kept as plain integers.
    int         m_ptr[2];
    bit         m_lock[2];
    int         m_lsel[2];
    logic [3:0] rv[2];
    bit         ro[2];
    bit         hold[2][4];
    int         waitc[2][4];
    logic [3:0] exp_q[$];

    function automatic bit has(input logic [3:0] v, input int w);
        return |(v & (4'b0001 << w));
    endfunction

    function automatic int pick(input int n, input int nw, input logic [3:0] iv);
        if (m_lock[n]) return has(iv, m_lsel[n]) ? m_lsel[n] : -1;
        for (int i = 0; i < nw; i++) begin
            if (has(iv, (m_ptr[n] + i) % nw)) return (m_ptr[n] + i) % nw;
        end
        return -1;
    endfunction

    function automatic bit lastbit(input int n, input int g);
`ifdef BASE_RRARB_LAST_EN
        return has(rl[n], g);
`else
        return (n >= 0) && (g >= 0);
`endif
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_ptr[n] = 0; m_lock[n] = 1'b0; m_lsel[n] = 0; rv[n] = 4'b0; ro[n] = 1'b0;
            for (int w = 0; w < 4; w++) begin
                hold[n][w] = 1'b0; waitc[n][w] = 0;
            end
        end
    endtask

    task automatic check_inst(input int n, input logic [3:0] a_sel, input logic [3:0] a_ir,
                              input logic a_ov, input logic [1:0] a_enc);
        int nw;
        int g;
        bit done;
        logic [3:0] es;
        nw = (n == 0) ? 4 : 3;
        g  = pick(n, nw, rv[n]);
        es = (g < 0) ? 4'b0 : (4'b0001 << g);
        exp_q.push_back(es);
        check((n == 0) ? "rnd_sel4" : "rnd_sel3", a_sel, exp_q.pop_front());
        check((n == 0) ? "rnd_enc4" : "rnd_enc3", a_enc, (g < 0) ? 0 : g);
        check((n == 0) ? "rnd_ov4" : "rnd_ov3", a_ov, g >= 0);
        check((n == 0) ? "rnd_ir4" : "rnd_ir3", a_ir, es & {4{ro[n]}});
        check((n == 0) ? "rnd_onehot4" : "rnd_onehot3", $onehot0(a_sel), 1);
        done = (g >= 0) && ro[n] && lastbit(n, g);
        if (done) begin
            for (int w = 0; w < nw; w++) begin
                if (w != g && has(rv[n], w)) begin
                    waitc[n][w]++;
                    check((n == 0) ? "starve4" : "starve3", waitc[n][w] <= nw - 1, 1);
                end
            end
            waitc[n][g] = 0;
        end
        for (int w = 0; w < nw; w++) begin
            if (!has(rv[n], w)) waitc[n][w] = 0;
        end
        if (g >= 0) begin
            if (!done) begin
                m_lock[n] = 1'b1; m_lsel[n] = g;
            end else begin
                m_lock[n] = 1'b0; m_ptr[n] = (g + 1) % nw;
            end
        end
        for (int w = 0; w < nw; w++) begin
            hold[n][w] = has(rv[n], w) && !(w == g && done);
        end
    endtask

    task automatic rand_cycle();
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < ((n == 0) ? 4 : 3); w++) begin
                if (!hold[n][w]) begin
                    if ($urandom_range(0, 99) < 45) rv[n] = rv[n] | (4'b0001 << w);
                    else                            rv[n] = rv[n] & ~(4'b0001 << w);
                end
            end
            ro[n] = ($urandom_range(0, 99) < 65);
`ifdef BASE_RRARB_LAST_EN
            rl[n] = 4'($urandom_range(0, 15));
`endif
        end
        iv4 = rv[0]; or4 = ro[0];
        iv3 = rv[1][2:0]; or3 = ro[1];
`ifdef BASE_RRARB_LAST_EN
        last4 = rl[0]; last3 = rl[1][2:0];
`endif
        #1;
        check_inst(0, sel4, ir4, ov4, enc4);
        check_inst(1, {1'b0, sel3}, {1'b0, ir3}, ov3, enc3);
    endtask

    task automatic drive4(input logic rst, input logic [3:0] iv, input logic o);
        @(negedge clk);
        reset = rst; iv4 = iv; or4 = o;
        #1;
    endtask

`ifdef BASE_RRARB_LAST_EN
    task automatic drive4l(input logic [3:0] iv, input logic [3:0] l);
        @(negedge clk);
        reset = 1'b0; iv4 = iv; or4 = 1'b1; last4 = l;
        #1;
    endtask
`endif

    task automatic exp4(input string tag, input logic [3:0] es, input logic [1:0] ee, input logic o);
        check({tag, "_sel"}, sel4, es);
        check({tag, "_enc"}, enc4, ee);
        check({tag, "_ov"}, ov4, |es);
        check({tag, "_ir"}, ir4, es & {4{o}});
    endtask

    initial begin
        reset = 1'b1; iv4 = '0; or4 = 1'b0; iv3 = '0; or3 = 1'b0;
`ifdef BASE_RRARB_LAST_EN
        last4 = '1; last3 = '1;
`endif
        drive4(1'b1, 4'b1111, 1'b1); exp4("rst_a", 4'b0000, 2'd0, 1'b1);
        drive4(1'b1, 4'b1111, 1'b1); exp4("rst_b", 4'b0000, 2'd0, 1'b1);

        for (int c = 0; c < 5; c++) begin
            drive4(1'b0, 4'b1111, 1'b1);
            exp4("rotate", 4'b0001 << (c % 4), 2'(c % 4), 1'b1);
        end

        for (int c = 0; c < 3; c++) begin
            drive4(1'b0, 4'b0100, 1'b0); exp4("stall", 4'b0100, 2'd2, 1'b0);
        end
        drive4(1'b0, 4'b0101, 1'b0); exp4("stall_hi", 4'b0100, 2'd2, 1'b0);
        drive4(1'b0, 4'b0101, 1'b1); exp4("stall_xfer", 4'b0100, 2'd2, 1'b1);
        drive4(1'b0, 4'b0011, 1'b1); exp4("wrap0", 4'b0001, 2'd0, 1'b1);
        drive4(1'b0, 4'b0011, 1'b1); exp4("wrap1", 4'b0010, 2'd1, 1'b1);
        drive4(1'b0, 4'b0000, 1'b1); exp4("idle", 4'b0000, 2'd0, 1'b1);
        drive4(1'b0, 4'b1111, 1'b0); exp4("after_idle", 4'b0100, 2'd2, 1'b0);
        drive4(1'b1, 4'b1111, 1'b1); exp4("rst_lock_a", 4'b0000, 2'd0, 1'b1);
        drive4(1'b1, 4'b0100, 1'b1); exp4("rst_lock_b", 4'b0000, 2'd0, 1'b1);
        drive4(1'b0, 4'b0110, 1'b1); exp4("post_rst", 4'b0010, 2'd1, 1'b1);

`ifdef BASE_RRARB_LAST_EN
        drive4l(4'b0001, 4'b1111); exp4("pkt_pre", 4'b0001, 2'd0, 1'b1);
        drive4l(4'b1111, 4'b0000); exp4("pkt_b0", 4'b0010, 2'd1, 1'b1);
        drive4l(4'b1111, 4'b0000); exp4("pkt_b1", 4'b0010, 2'd1, 1'b1);
        drive4l(4'b1111, 4'b0010); exp4("pkt_b2", 4'b0010, 2'd1, 1'b1);
        drive4l(4'b1111, 4'b1111); exp4("pkt_next", 4'b0100, 2'd2, 1'b1);
`endif

        @(negedge clk);
        reset = 1'b1; iv4 = '0; or4 = 1'b0; iv3 = '0; or3 = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            rand_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
